// File: rtl/rx_conn_arbiter.sv
// rx_conn_arbiter: packet-level merger of up to 16 per-connection receive
// streams into one tagged stream for rx_switch. A grant is held from the
// first beat of a packet through its last beat, so packets never interleave.
// The output stage is a registered one-entry slice.
// Optional build macro RX_ARB_FIXED_PRIO_EN: IDLE arbitration becomes fixed
// lowest-index-first and the round-robin pointer is removed.
module rx_conn_arbiter #(
   parameter int N_CONN = 4,
   parameter int DW     = 128
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_CONN*DW-1:0] in_data,
   input  logic [N_CONN-1:0]    in_last,
   input  logic [N_CONN-1:0]    in_valid,
   output logic [N_CONN-1:0]    in_ready,
   output logic [DW-1:0]        rx_data,
   output logic [3:0]           rx_connection_id,
   output logic                 rx_last,
   output logic                 rx_valid,
   input  logic                 rx_ready
);

   typedef enum logic [0:0] {IDLE, LOCK} state_t;

   state_t            state_reg, state_next;
   logic [3:0]        grant_reg, grant_next;

   logic              load;
   logic              pick_found;
   logic [3:0]        pick_idx;
   logic              sel_en;
   logic [3:0]        sel_idx;
   logic [N_CONN-1:0] ready_vec;
   logic              xfer;
   logic              xfer_last;
   logic [DW-1:0]     xfer_data;
   logic [DW-1:0]     conn_data [N_CONN];

   logic [DW-1:0]     rx_data_reg;
   logic [3:0]        rx_id_reg;
   logic              rx_last_reg;
   logic              rx_valid_reg;

   // The output slice may take a new beat when empty or being drained.
   assign load = ~rx_valid_reg | rx_ready;

   // Per-connection data slices and the one-hot ready toward the selected source.
   generate
      for (genvar gi = 0; gi < N_CONN; gi++) begin : g_conn
         assign conn_data[gi] = in_data[gi*DW +: DW];
         assign ready_vec[gi] = sel_en & load & (sel_idx == 4'(gi));
      end
   endgenerate

   // Ready is forced low while reset is held, even though load is 1 then.
   assign in_ready = ready_vec & {N_CONN{reset_n}};
   assign xfer     = |(in_valid & in_ready);

`ifndef RX_ARB_FIXED_PRIO_EN
   logic [3:0] rr_ptr_reg, rr_ptr_next;

   // Round-robin pick: lowest valid index above rr_ptr, else lowest valid overall.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = N_CONN - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            pick_found = 1'b1;
            pick_idx   = 4'(i);
         end
      end
      for (int i = N_CONN - 1; i >= 0; i--) begin
         if (in_valid[i] && (4'(i) > rr_ptr_reg)) begin
            pick_idx = 4'(i);
         end
      end
   end
`else
   // Fixed-priority pick: lowest valid index wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = N_CONN - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            pick_found = 1'b1;
            pick_idx   = 4'(i);
         end
      end
   end
`endif

   // Select the source: the fresh pick in IDLE, the held grant in LOCK.
   always_comb begin
      sel_en  = 1'b0;
      sel_idx = pick_idx;
      case (state_reg)
         IDLE: begin
            sel_en  = pick_found;
            sel_idx = pick_idx;
         end
         LOCK: begin
            sel_en  = 1'b1;
            sel_idx = grant_reg;
         end
         default: begin
            sel_en  = 1'b0;
            sel_idx = pick_idx;
         end
      endcase
   end

   // Mux the selected connection's beat toward the output slice.
   always_comb begin
      xfer_data = '0;
      xfer_last = 1'b0;
      for (int i = 0; i < N_CONN; i++) begin
         if (sel_idx == 4'(i)) begin
            xfer_data = conn_data[i];
            xfer_last = in_last[i];
         end
      end
   end

   // Next-state logic: lock on a non-final first beat, release on the last beat.
   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
`ifndef RX_ARB_FIXED_PRIO_EN
      rr_ptr_next = rr_ptr_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (xfer) begin
               if (xfer_last) begin
`ifndef RX_ARB_FIXED_PRIO_EN
                  rr_ptr_next = sel_idx;
`endif
               end else begin
                  state_next = LOCK;
                  grant_next = sel_idx;
               end
            end
         end
         LOCK: begin
            if (xfer && xfer_last) begin
               state_next = IDLE;
`ifndef RX_ARB_FIXED_PRIO_EN
               rr_ptr_next = grant_reg;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         grant_reg  <= '0;
`ifndef RX_ARB_FIXED_PRIO_EN
         rr_ptr_reg <= 4'(N_CONN - 1);
`endif
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
`ifndef RX_ARB_FIXED_PRIO_EN
         rr_ptr_reg <= rr_ptr_next;
`endif
      end
   end

   // Output slice: capture on transfer, empty when drained with nothing new, else hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_valid_reg <= 1'b0;
         rx_data_reg  <= '0;
         rx_id_reg    <= '0;
         rx_last_reg  <= 1'b0;
      end else if (load) begin
         rx_valid_reg <= xfer;
         if (xfer) begin
            rx_data_reg <= xfer_data;
            rx_id_reg   <= sel_idx;
            rx_last_reg <= xfer_last;
         end
      end
   end

   assign rx_data          = rx_data_reg;
   assign rx_connection_id = rx_id_reg;
   assign rx_last          = rx_last_reg;
   assign rx_valid         = rx_valid_reg;

endmodule

// File: tb/tb_rx_conn_arbiter.sv
// Directed bench for rx_conn_arbiter: per-connection packet sources, an
// output beat recorder, and hand-written expected beat sequences.
module tb_rx_conn_arbiter;

   localparam int NC = 4;
   localparam int DW = 128;

   logic             clk;
   logic             reset_n;
   logic [NC*DW-1:0] in_data;
   logic [NC-1:0]    in_last;
   logic [NC-1:0]    in_valid;
   logic [NC-1:0]    in_ready;
   logic [DW-1:0]    rx_data;
   logic [3:0]       rx_connection_id;
   logic             rx_last;
   logic             rx_valid;
   logic             rx_ready;

   rx_conn_arbiter #(.N_CONN(NC), .DW(DW)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .in_data          (in_data),
      .in_last          (in_last),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .rx_data          (rx_data),
      .rx_connection_id (rx_connection_id),
      .rx_last          (rx_last),
      .rx_valid         (rx_valid),
      .rx_ready         (rx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int test_no = 0;

   // source model
   int src_total [NC];
   int src_pos   [NC];
   int pkt_len   [NC];
   bit pause     [NC];

   // recorded output beats
   int            got_id   [$];
   logic [DW-1:0] got_data [$];
   logic          got_last [$];
   int            got_cyc  [$];

   // expected beats
   int e_id  [$];
   int e_pos [$];
   bit e_last[$];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mkdata(input int c, input int pos);
      return {96'hC0DE_0000_0000_0000_0000_0000, 8'(test_no), 8'(c), 8'(pos), 8'hA1};
   endfunction

   task automatic drive();
      for (int c = 0; c < NC; c++) begin
         in_valid[c] = (src_pos[c] < src_total[c]) && !pause[c];
         in_last[c]  = ((src_pos[c] + 1) % pkt_len[c]) == 0;
         in_data[c*DW +: DW] = mkdata(c, src_pos[c]);
      end
   endtask

   task automatic start_src(input int c, input int beats, input int len);
      src_total[c] = beats;
      src_pos[c]   = 0;
      pkt_len[c]   = len;
      pause[c]     = 1'b0;
   endtask

   task automatic clear_all();
      for (int c = 0; c < NC; c++) start_src(c, 0, 1);
      got_id.delete(); got_data.delete(); got_last.delete(); got_cyc.delete();
      e_id.delete(); e_pos.delete(); e_last.delete();
   endtask

   task automatic exp_beat(input int c, input int pos, input bit last);
      e_id.push_back(c);
      e_pos.push_back(pos);
      e_last.push_back(last);
   endtask

   // One clock: record handshakes at the falling edge, advance sources after the rising edge.
   task automatic tick();
      logic [NC-1:0] hs;
      @(negedge clk);
      hs = in_valid & in_ready;
      if (rx_valid && rx_ready) begin
         got_id.push_back(int'(rx_connection_id));
         got_data.push_back(rx_data);
         got_last.push_back(rx_last);
         got_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < NC; c++) if (hs[c]) src_pos[c]++;
      drive();
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      bit done;
      done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         tick();
         done = !rx_valid;
         for (int c = 0; c < NC; c++) if (src_pos[c] < src_total[c]) done = 1'b0;
      end
      chk({tag, "_drain_done"}, done, 1);
   endtask

   task automatic check_got(input string tag, input bit gapless);
      chk({tag, "_count"}, got_id.size(), e_id.size());
      for (int k = 0; k < e_id.size() && k < got_id.size(); k++) begin
         chk($sformatf("%s_id%0d", tag, k), got_id[k], e_id[k]);
         chk($sformatf("%s_data%0d", tag, k), got_data[k], mkdata(e_id[k], e_pos[k]));
         chk($sformatf("%s_last%0d", tag, k), got_last[k], e_last[k]);
         if (gapless && k > 0)
            chk($sformatf("%s_gap%0d", tag, k), got_cyc[k] - got_cyc[k-1], 1);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      rx_ready = 1'b1;
      in_data  = '0;
      in_last  = '0;
      clear_all();
      in_valid = '1;
      // reset state, with all inputs requesting
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_id", rx_connection_id, 0);
      chk("rst_rx_last", rx_last, 0);
      chk("rst_in_ready", in_ready, 0);
      drive();
      reset_n = 1'b1;
      #1;
      $display("reset released, in_ready=%b rx_valid=%b", in_ready, rx_valid);

      // 1) single-beat packet on conn2
      test_no = 1;
      start_src(2, 1, 1);
      drive();
      #1;
      chk("t1_in_ready", in_ready, 4'b0100);
      tick();
      chk("t1_rx_valid", rx_valid, 1);
      chk("t1_rx_data", rx_data, mkdata(2, 0));
      chk("t1_rx_id", rx_connection_id, 2);
      chk("t1_rx_last", rx_last, 1);
      $display("t1 beat: id=%0d last=%b data=%h", rx_connection_id, rx_last, rx_data);
      tick();
      chk("t1_rx_valid_after", rx_valid, 0);

      // 2) conn0 and conn1 three-beat packets, same start cycle
      test_no = 2;
      clear_all();
      start_src(0, 3, 3);
      start_src(1, 3, 3);
      drive();
      #1;
      for (int b = 0; b < 3; b++) exp_beat(0, b, b == 2);
      for (int b = 0; b < 3; b++) exp_beat(1, b, b == 2);
      drain("t2", 40);
      check_got("t2", 1'b1);
      $display("t2 beats=%0d", got_id.size());

      // 3) all connections offering single-beat packets
      test_no = 3;
      clear_all();
      for (int c = 0; c < NC; c++) start_src(c, 2, 1);
      drive();
      #1;
      exp_beat(2, 0, 1); exp_beat(3, 0, 1); exp_beat(0, 0, 1); exp_beat(1, 0, 1);
      exp_beat(2, 1, 1); exp_beat(3, 1, 1); exp_beat(0, 1, 1); exp_beat(1, 1, 1);
      drain("t3", 40);
      check_got("t3", 1'b1);
      $display("t3 beats=%0d", got_id.size());

      // 4) downstream stall mid-packet
      test_no = 4;
      clear_all();
      start_src(0, 4, 4);
      drive();
      #1;
      tick();
      tick();
      rx_ready = 1'b0;
      #1;
      for (int s = 0; s < 5; s++) begin
         tick();
         chk($sformatf("t4_stall_ready%0d", s), in_ready, 0);
         chk($sformatf("t4_stall_valid%0d", s), rx_valid, 1);
         chk($sformatf("t4_stall_data%0d", s), rx_data, mkdata(0, 1));
      end
      rx_ready = 1'b1;
      #1;
      for (int b = 0; b < 4; b++) exp_beat(0, b, b == 3);
      drain("t4", 40);
      check_got("t4", 1'b0);
      $display("t4 beats=%0d", got_id.size());

      // 5) conn1 pauses mid-packet while conn3 waits
      test_no = 5;
      clear_all();
      start_src(1, 4, 4);
      start_src(3, 1, 1);
      drive();
      #1;
      tick();
      tick();
      pause[1] = 1'b1;
      drive();
      #1;
      chk("t5_pause_ready0", in_ready, 4'b0010);
      tick();
      chk("t5_pause_ready1", in_ready, 4'b0010);
      chk("t5_pause_valid1", rx_valid, 0);
      tick();
      chk("t5_pause_ready2", in_ready, 4'b0010);
      chk("t5_pause_valid2", rx_valid, 0);
      pause[1] = 1'b0;
      drive();
      #1;
      for (int b = 0; b < 4; b++) exp_beat(1, b, b == 3);
      exp_beat(3, 0, 1);
      drain("t5", 40);
      check_got("t5", 1'b0);
      $display("t5 beats=%0d", got_id.size());

      // 6) reset during a four-beat packet, then arbitration restarts at conn0
      test_no = 6;
      clear_all();
      start_src(2, 4, 4);
      drive();
      #1;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk("t6_async_valid", rx_valid, 0);
      chk("t6_async_data", rx_data, 0);
      chk("t6_async_ready", in_ready, 0);
      clear_all();
      drive();
      tick();
      tick();
      reset_n = 1'b1;
      start_src(2, 4, 4);
      start_src(0, 1, 1);
      drive();
      #1;
      chk("t6_first_ready", in_ready, 4'b0001);
      exp_beat(0, 0, 1);
      for (int b = 0; b < 4; b++) exp_beat(2, b, b == 3);
      drain("t6", 40);
      check_got("t6", 1'b1);
      $display("t6 beats=%0d", got_id.size());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
